chunk_distributor: RTL and testbench

Downstream consumer of the divider stage in the accelerator-parallelism socket. Takes one (quotient, remainder) result for a transfer of length L split across N_ACC accelerators, plus the transfer base offset, and emits N_ACC per-accelerator chunk descriptors, one per handshake, in accelerator index order. The first `remainder` accelerators receive `quotient+1` elements and the rest receive `quotient`. Offsets are contiguous from the base.

---
 rtl/acc_par_pkg.sv | 21 ++
 rtl/chunk_distributor_if.sv | 35 +++
 rtl/chunk_distributor_chk.sv | 17 +
 rtl/chunk_distributor.sv | 111 +++++++++++
 tb/tb_chunk_distributor.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/acc_par_pkg.sv
// Shared types for the accelerator-parallelism socket: chunk FSM states and
// the per-accelerator chunk descriptor.
package acc_par_pkg;

  localparam int unsigned NBITS    = 8;
  localparam int unsigned N_ACC    = 4;
  localparam int unsigned IDX_BITS = $clog2(N_ACC);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } chunk_state_t;

  typedef struct packed {
    logic [IDX_BITS-1:0] index;
    logic [NBITS-1:0]    offset;
    logic [NBITS-1:0]    length;
    logic                last;
  } chunk_desc_t;

endpackage

// File: rtl/chunk_distributor_if.sv
// Job input and descriptor output handshakes of the chunk distributor.
// master = job producer / descriptor consumer, slave = the distributor.
interface chunk_distributor_if #(
  parameter int unsigned NBITS    = 8,
  parameter int unsigned N_ACC    = 4,
  parameter int unsigned IDX_BITS = $clog2(N_ACC)
);

  logic                in_valid_i;
  logic [NBITS-1:0]    in_quotient_i;
  logic [NBITS-1:0]    in_remainder_i;
  logic [NBITS-1:0]    in_base_i;
  logic                in_ready_o;
  logic                out_valid_o;
  logic [IDX_BITS-1:0] out_index_o;
  logic [NBITS-1:0]    out_offset_o;
  logic [NBITS-1:0]    out_length_o;
  logic                out_last_o;
  logic                out_ready_i;

  modport master (
    output in_valid_i, in_quotient_i, in_remainder_i, in_base_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_index_o, out_offset_o, out_length_o, out_last_o
  );

  modport slave (
    input  in_valid_i, in_quotient_i, in_remainder_i, in_base_i, out_ready_i,
    output in_ready_o, out_valid_o, out_index_o, out_offset_o, out_length_o, out_last_o
  );

  modport mon (
    input in_valid_i, in_ready_o, in_remainder_i
  );

endinterface

// File: rtl/chunk_distributor_chk.sv
// Simulation-only checker: flags a job accepted with remainder >= N_ACC.
module chunk_distributor_chk #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned N_ACC = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  chunk_distributor_if.mon bus
);

  // An illegal remainder still emits N_ACC chunks of q+1; this makes it visible.
  a_legal_remainder: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (bus.in_valid_i && bus.in_ready_o) |-> (bus.in_remainder_i < NBITS'(N_ACC))
  ) else $error("chunk_distributor: illegal remainder %0d", bus.in_remainder_i);

endmodule

// File: rtl/chunk_distributor.sv
// Splits one (quotient, remainder, base) job into N_ACC contiguous chunk
// descriptors, one per handshake; the first `remainder` chunks get one extra element.
module chunk_distributor
  import acc_par_pkg::*;
#(
  parameter int unsigned NBITS    = 8,
  parameter int unsigned N_ACC    = 4,
  parameter int unsigned IDX_BITS = $clog2(N_ACC)
) (
  input logic clk_i,
  input logic rst_i,
  chunk_distributor_if.slave bus
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_ACC - 1);

  function automatic logic [NBITS-1:0] chunk_len(input logic [NBITS-1:0]    q,
                                                 input logic [NBITS-1:0]    r,
                                                 input logic [IDX_BITS-1:0] idx);
    if (NBITS'(idx) < r) begin
      return q + NBITS'(1);
    end else begin
      return q;
    end
  endfunction

  chunk_state_t        state_q;
  logic [NBITS-1:0]    q_q;
  logic [NBITS-1:0]    r_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [IDX_BITS-1:0] out_index_q;
  logic [NBITS-1:0]    out_offset_q;
  logic [NBITS-1:0]    out_length_q;
  logic                out_last_q;

  logic [IDX_BITS-1:0] idx_d;
  logic [NBITS-1:0]    offset_d;
  logic [NBITS-1:0]    length_d;

  // Next descriptor in the sequence; offset wraps modulo 2^NBITS.
  always_comb begin
    idx_d    = out_index_q + IDX_BITS'(1);
    offset_d = out_offset_q + out_length_q;
    length_d = chunk_len(q_q, r_q, idx_d);
  end

  // Job FSM; every output is a register so ready never follows out_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      q_q          <= '0;
      r_q          <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_offset_q <= '0;
      out_length_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i && in_ready_q) begin
            state_q      <= EMIT;
            q_q          <= bus.in_quotient_i;
            r_q          <= bus.in_remainder_i;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b1;
            out_index_q  <= '0;
            out_offset_q <= bus.in_base_i;
            out_length_q <= chunk_len(bus.in_quotient_i, bus.in_remainder_i, '0);
            out_last_q   <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.out_ready_i) begin
            if (out_index_q == LAST_IDX) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              out_index_q  <= idx_d;
              out_offset_q <= offset_d;
              out_length_q <= length_d;
              out_last_q   <= (idx_d == LAST_IDX);
            end
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o   = in_ready_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_index_o  = out_index_q;
  assign bus.out_offset_o = out_offset_q;
  assign bus.out_length_o = out_length_q;
  assign bus.out_last_o   = out_last_q;

endmodule

// File: tb/tb_chunk_distributor.sv
// Scoreboard bench for chunk_distributor: directed jobs push hand-computed
// descriptors; a negedge monitor compares every presented descriptor.
module tb_chunk_distributor;
  import acc_par_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  chunk_distributor_if #(.NBITS(NBITS), .N_ACC(N_ACC)) bus_if ();

  chunk_distributor #(.NBITS(NBITS), .N_ACC(N_ACC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  chunk_distributor_chk #(.NBITS(NBITS), .N_ACC(N_ACC)) u_chk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_desc  = 0;
  chunk_desc_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int off, input int len);
    chunk_desc_t d;
    d.index  = IDX_BITS'(idx);
    d.offset = NBITS'(off);
    d.length = NBITS'(len);
    d.last   = (idx == N_ACC - 1);
    exp_q.push_back(d);
  endtask

  // Compare every presented descriptor (including stalled ones) with the queue head.
  always @(negedge clk_i) begin
    if (!rst_i && bus_if.out_valid_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_desc: got index %0d offset 0x%0h, expected none",
                 bus_if.out_index_o, bus_if.out_offset_o);
      end else begin
        check("desc_index",  32'(bus_if.out_index_o),  32'(exp_q[0].index));
        check("desc_offset", 32'(bus_if.out_offset_o), 32'(exp_q[0].offset));
        check("desc_length", 32'(bus_if.out_length_o), 32'(exp_q[0].length));
        check("desc_last",   32'(bus_if.out_last_o),   32'(exp_q[0].last));
        if (bus_if.out_ready_i) begin
          void'(exp_q.pop_front());
          n_desc++;
        end
      end
    end
  end

  task automatic start_job(input int q, input int r, input int base);
    int i;
    i = 0;
    while (!bus_if.in_ready_o && i < 20) begin
      @(posedge clk_i); #1;
      i++;
    end
    check("accept_ready", 32'(bus_if.in_ready_o), 32'd1);
    bus_if.in_valid_i     = 1'b1;
    bus_if.in_quotient_i  = NBITS'(q);
    bus_if.in_remainder_i = NBITS'(r);
    bus_if.in_base_i      = NBITS'(base);
    @(posedge clk_i); #1;
    bus_if.in_valid_i = 1'b0;
    check("latency_valid", 32'(bus_if.out_valid_o), 32'd1);
    check("busy_not_ready", 32'(bus_if.in_ready_o), 32'd0);
  endtask

  task automatic drain(input logic [3:0] pat, input bit hold);
    int  c;
    bit  done;
    c    = 0;
    done = 1'b0;
    while (!done && c < 60) begin
      bus_if.out_ready_i = pat[c % 4];
      if (hold) begin
        bus_if.in_valid_i     = 1'b1;
        bus_if.in_quotient_i  = NBITS'($urandom_range(0, 100));
        bus_if.in_remainder_i = NBITS'($urandom_range(0, N_ACC - 1));
        bus_if.in_base_i      = NBITS'($urandom_range(0, 255));
      end
      @(posedge clk_i); #1;
      c++;
      if (bus_if.in_ready_o) done = 1'b1;
    end
    bus_if.in_valid_i  = 1'b0;
    bus_if.out_ready_i = 1'b0;
    check("job_done_in_time", 32'(done), 32'd1);
    check("after_last_valid", 32'(bus_if.out_valid_o), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c;
    bus_if.in_valid_i     = 1'b0;
    bus_if.in_quotient_i  = '0;
    bus_if.in_remainder_i = '0;
    bus_if.in_base_i      = '0;
    bus_if.out_ready_i    = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_out_valid",  32'(bus_if.out_valid_o),  32'd0);
    check("rst_out_last",   32'(bus_if.out_last_o),   32'd0);
    check("rst_out_index",  32'(bus_if.out_index_o),  32'd0);
    check("rst_out_offset", 32'(bus_if.out_offset_o), 32'd0);
    check("rst_out_length", 32'(bus_if.out_length_o), 32'd0);
    check("rst_in_ready",   32'(bus_if.in_ready_o),   32'd1);
    rst_i = 1'b0;

    // q=3 r=2 base=0x10, ready held high
    n_desc = 0;
    push(0, 'h10, 4); push(1, 'h14, 4); push(2, 'h18, 3); push(3, 'h1B, 3);
    start_job(3, 2, 'h10);
    drain(4'b1111, 1'b0);
    check("jobA_count", 32'(n_desc), 32'd4);

    // q=0 r=1: one length-1 chunk followed by zero-length chunks
    n_desc = 0;
    push(0, 0, 1); push(1, 1, 0); push(2, 1, 0); push(3, 1, 0);
    start_job(0, 1, 0);
    drain(4'b1111, 1'b0);
    check("jobB_count", 32'(n_desc), 32'd4);

    // q=5 r=0 base=0xF0 with ready pattern 1,0,0,1
    n_desc = 0;
    push(0, 'hF0, 5); push(1, 'hF5, 5); push(2, 'hFA, 5); push(3, 'hFF, 5);
    start_job(5, 0, 'hF0);
    drain(4'b1001, 1'b0);
    check("jobC_count", 32'(n_desc), 32'd4);

    // q=0x20 r=3 base=0xE0: offsets wrap past 0xFF
    n_desc = 0;
    push(0, 'hE0, 'h21); push(1, 'h01, 'h21); push(2, 'h22, 'h21); push(3, 'h43, 'h20);
    start_job('h20, 3, 'hE0);
    drain(4'b1111, 1'b0);
    check("jobD_count", 32'(n_desc), 32'd4);

    // reset while descriptor 2 is presented
    push(0, 'h10, 4); push(1, 'h14, 4); push(2, 'h18, 3); push(3, 'h1B, 3);
    start_job(3, 2, 'h10);
    bus_if.out_ready_i = 1'b1;
    c = 0;
    while (!(bus_if.out_valid_o && bus_if.out_index_o == IDX_BITS'(2)) && c < 20) begin
      @(posedge clk_i); #1;
      c++;
    end
    check("reached_desc2", 32'(bus_if.out_index_o), 32'd2);
    bus_if.out_ready_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    check("midrst_out_valid",  32'(bus_if.out_valid_o),  32'd0);
    check("midrst_out_last",   32'(bus_if.out_last_o),   32'd0);
    check("midrst_out_index",  32'(bus_if.out_index_o),  32'd0);
    check("midrst_out_offset", 32'(bus_if.out_offset_o), 32'd0);
    check("midrst_out_length", 32'(bus_if.out_length_o), 32'd0);
    check("midrst_in_ready",   32'(bus_if.in_ready_o),   32'd1);

    n_desc = 0;
    push(0, 0, 1); push(1, 1, 1); push(2, 2, 1); push(3, 3, 1);
    start_job(1, 0, 0);
    drain(4'b1111, 1'b0);
    check("jobE_count", 32'(n_desc), 32'd4);

    // in_valid held high with changing data during EMIT
    n_desc = 0;
    push(0, 'h30, 3); push(1, 'h33, 2); push(2, 'h35, 2); push(3, 'h37, 2);
    start_job(2, 1, 'h30);
    drain(4'b1111, 1'b1);
    check("jobF_count", 32'(n_desc), 32'd4);
    @(posedge clk_i); #1;
    check("no_second_accept", 32'(bus_if.out_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
